// File: rtl/adder_pipe_nbit.sv
// adder_pipe_nbit: pipelined adder built from ripple slices, for wide operands.
//
// The WIDTH-bit operands are split into SLICE-bit slices. Each pipeline stage adds
// one slice, and the carry is registered between stages. The adder accepts one
// operation per cycle and has a valid/ready handshake on both sides. The latency is
// STAGES = WIDTH/SLICE cycles.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   a/b/cin (and sub) are valid
//   in_ready   operands are accepted this cycle (same as the pipeline advance)
//   a, b       WIDTH-bit operands (unsigned or two's complement)
//   cin        carry-in (borrow-in when subtracting)
//   sub        subtract select; this port exists only with ADDER_PIPE_SUB_EN
//   out_valid  sum/cout/ovf are valid
//   out_ready  downstream accepts the result this cycle
//   sum        (a + b + cin) mod 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   ovf        signed overflow
//
// Optional feature: define ADDER_PIPE_SUB_EN to add the sub input. With sub=1,
// stage 0 adds ~b with carry-in ~cin, which gives a - b - cin.

module adder_pipe_nbit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_PIPE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = WIDTH / SLICE;
  localparam int unsigned LAST   = STAGES - 1;

  if (SLICE < 1 || WIDTH < SLICE || (WIDTH % SLICE) != 0) begin : g_cfg_check
    $error("adder_pipe_nbit: WIDTH must be a non-zero multiple of SLICE");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef ADDER_PIPE_SUB_EN
  // Two's-complement subtract: a + ~b + ~cin = a - b - cin
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? ~cin : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  // Per-stage registers. Stage k holds its operands, the low sum slices
  // 0..k and the carry out of slice k.
  logic             valid_q [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] s_q     [STAGES];
  logic             c_q     [STAGES];

  // Inputs to each stage: stage 0 takes the ports, later stages take the previous register.
  logic             stg_v [STAGES];
  logic [WIDTH-1:0] stg_a [STAGES];
  logic [WIDTH-1:0] stg_b [STAGES];
  logic [WIDTH-1:0] stg_s [STAGES];
  logic             stg_c [STAGES];

  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_d [STAGES];
  logic [SLICE:0]   slice_res;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage_in
    if (k == 0) begin : g_head
      assign stg_v[k] = in_valid;
      assign stg_a[k] = a;
      assign stg_b[k] = b_eff;
      assign stg_c[k] = cin_eff;
      assign stg_s[k] = '0;
    end else begin : g_body
      assign stg_v[k] = valid_q[k-1];
      assign stg_a[k] = a_q[k-1];
      assign stg_b[k] = b_q[k-1];
      assign stg_c[k] = c_q[k-1];
      assign stg_s[k] = s_q[k-1];
    end
  end

  always_comb begin
    slice_res = '0;
    for (int k = 0; k < STAGES; k++) begin
      slice_res = {1'b0, stg_a[k][k*SLICE +: SLICE]}
                + {1'b0, stg_b[k][k*SLICE +: SLICE]}
                + {{SLICE{1'b0}}, stg_c[k]};
      // Keep the lower slices that are already finished and write this stage's slice.
      s_d[k]                   = stg_s[k];
      s_d[k][k*SLICE +: SLICE] = slice_res[SLICE-1:0];
      c_d[k]                   = slice_res[SLICE];
    end
  end

  // The whole pipeline shifts together. Bubbles shift through as invalid stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        s_q[k]     <= '0;
        c_q[k]     <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= stg_v[k];
        a_q[k]     <= stg_a[k];
        b_q[k]     <= stg_b[k];
        s_q[k]     <= s_d[k];
        c_q[k]     <= c_d[k];
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
  // Carry into the MSB is a^b^s at that bit. XOR it with the carry out to get overflow.
  assign ovf       = a_q[LAST][WIDTH-1] ^ b_q[LAST][WIDTH-1] ^ s_q[LAST][WIDTH-1] ^ c_q[LAST];

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Testbench for adder_pipe_nbit. The main instance is 16/4 and a second instance is 8/8.
// Directed vectors with hand-computed results, plus a scoreboard on the output handshake.

module tb_adder_pipe_nbit;

  localparam int unsigned W = 16;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b1;
  logic         cin       = 1'b0;
  logic         sub_s     = 1'b0;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         in_ready, out_valid, cout, ovf;
  logic [W-1:0] sum;

  logic         in_valid8 = 1'b0;
  logic         cin8      = 1'b0;
  logic [7:0]   a8        = '0;
  logic [7:0]   b8        = '0;
  logic         in_ready8, out_valid8, cout8, ovf8;
  logic [7:0]   sum8;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_acc   = 0;
  int           n_out   = 0;
  logic [31:0]  exp_q[$];
  logic [31:0]  exp_e;

  always #5 clk = ~clk;

  adder_pipe_nbit #(.WIDTH(16), .SLICE(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADDER_PIPE_SUB_EN
    .sub       (sub_s),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  adder_pipe_nbit #(.WIDTH(8), .SLICE(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
`ifdef ADDER_PIPE_SUB_EN
    .sub       (1'b0),
`endif
    .out_valid (out_valid8),
    .out_ready (1'b1),
    .sum       (sum8),
    .cout      (cout8),
    .ovf       (ovf8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference result packed as {cout, ovf, sum}
  function automatic logic [31:0] model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                        input logic fc, input logic fs);
    logic [W-1:0] bb;
    logic         cc;
    logic [W:0]   t;
    logic         o;
    bb = fs ? ~fb : fb;
    cc = fs ? ~fc : fc;
    t  = {1'b0, fa} + {1'b0, bb} + {{W{1'b0}}, cc};
    o  = (fa[W-1] == bb[W-1]) && (t[W-1] != fa[W-1]);
    return {14'd0, t[W], o, t[W-1:0]};
  endfunction

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'd1, 32'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check("scb_result", {14'd0, cout, ovf, sum}, exp_e);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub_s));
        n_acc++;
      end
    end
  end

  task automatic send_and_check(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                input logic tc, input logic [W-1:0] es, input logic ec,
                                input logic eo);
    int lat;
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd4);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    step();
  endtask

  initial begin
    logic [15:0]  hist;
    logic [7:0]   hist8;
    logic [W-1:0] fa [5];
    logic [W-1:0] fb [5];
    logic         fc [5];
    int           cnt;

    // Reset state
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid8", 32'(out_valid8), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors
    send_and_check("carry_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_and_check("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    send_and_check("cin_ripple", 16'h00F0, 16'h0F0F, 1'b1, 16'h1000, 1'b0, 1'b0);
    send_and_check("neg_ovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
`ifdef ADDER_PIPE_SUB_EN
    sub_s = 1'b1;
    send_and_check("sub_borrow", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    sub_s = 1'b0;
`endif

    // 8 back-to-back random ops: expect valid on samples 3..10
    for (int i = 0; i < 16; i++) begin
      if (i < 8) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      hist[i] = out_valid;
    end
    check("b2b_valid_pattern", 32'(hist), 32'h0000_07F8);
    check("b2b_drained", 32'(exp_q.size()), 32'd0);

    // Fill the pipeline with out_ready=0, then stall for 3 cycles
    fa = '{16'h1234, 16'h8000, 16'hFFFF, 16'h4000, 16'h0001};
    fb = '{16'h1111, 16'h8000, 16'hFFFF, 16'h4000, 16'h0002};
    fc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = fa[i]; b = fb[i]; cin = fc[i]; in_valid = 1'b1;
      step();
    end
    a = fa[4]; b = fb[4]; cin = fc[4];
    for (int j = 0; j < 3; j++) begin
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_sum", 32'(sum), 32'h2345);
      check("stall_cout", 32'(cout), 32'd0);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      hist8[i] = out_valid;
      step();
      if (i == 0) in_valid = 1'b0;
    end
    check("drain_valid_pattern", 32'(hist8), 32'h0000_001F);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_count", 32'(n_out), 32'(n_acc));

    // Reset with ops in flight
    for (int i = 0; i < 4; i++) begin
      a = fa[i]; b = fb[i]; cin = fc[i]; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) cnt++;
    end
    check("post_rst_no_stale", 32'(cnt), 32'd0);
    send_and_check("post_rst_op", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

    // Single-stage instance: registered adder with 1-cycle latency
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; in_valid8 = 1'b1;
    check("w8_in_ready", 32'(in_ready8), 32'd1);
    step();
    in_valid8 = 1'b0;
    check("w8_valid_lat1", 32'(out_valid8), 32'd1);
    check("w8_sum", 32'(sum8), 32'h80);
    check("w8_cout", 32'(cout8), 32'd0);
    check("w8_ovf", 32'(ovf8), 32'd1);
    step();
    check("w8_no_dup", 32'(out_valid8), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
